door_lock_sequencer: RTL and testbench
======================================

// Module: door_lock_sequencer
// PURPOSE
//  Command side of the door-sensor interface: drives lock actuators for doors A-D one at a time and
//  confirms each against its bolt feedback and door-open sensor. Sits beside the door status
//  monitor. It accepts a lock/unlock request, sequences doors A->D, and reports done or a fault
//  (door open, or actuator timeout). Door sensor convention: Door[i]=1 means the door is open.
// PARAMETERS
//  SETTLE_CYCLES   4     consecutive cycles LockFb[i]==cmd required to confirm a door (>=1)
//  TIMEOUT_CYCLES  64    max cycles spent waiting per door before timeout fault (> SETTLE_CYCLES)
// PORTS
//  clk        in   1  single clock, all logic on rising edge
//  reset      in   1  synchronous, active-high
//  Req        in   1  request valid; accepted on the cycle Req & Ready
//  Cmd        in   1  1=lock, 0=unlock; sampled only at acceptance
//  Ready      out  1  high only in IDLE
//  Clear      in   1  acknowledges a fault; honoured only in FAULT
//  Door       in   4  [0]=A..[3]=D, 1=open
//  LockFb     in   4  bolt feedback, 1=bolt engaged
//  LockCmd    out  4  actuator drive, 1=engage bolt; registered
//  Busy       out  1  high in every state except IDLE and FAULT
//  Done       out  1  one-cycle pulse on successful completion
//  Fault      out  1  high while in FAULT
//  FaultCause out  2  0=none, 1=door open, 2=timeout; valid while Fault
//  FaultDoor  out  2  index of the failing door; valid while Fault
// BEHAVIOUR
//  Reset: state IDLE; LockCmd=4'b0000 (fail-safe unlocked); Ready=1; Busy/Done/Fault=0;
//   FaultCause/FaultDoor=0; idx, counters and latched cmd=0. Reset mid-sequence aborts immediately.
//  FSM (all outputs registered or decoded from state):
//   IDLE:    Ready=1. Req&Ready -> latch Cmd, idx=0 -> CHECK. Req while not Ready is ignored, not queued.
//   CHECK:   cmd=1 & Door[idx]=1 -> FAULT (cause 1, FaultDoor=idx); else -> DRIVE.
//   DRIVE:   LockCmd[idx]<=cmd; settle_cnt=0, wait_cnt=0 -> WAIT_FB.
//   WAIT_FB: each cycle wait_cnt++. If LockFb[idx]==cmd, settle_cnt++; else settle_cnt=0.
//            Priority, highest first:
//             cmd=1 & Door[idx]=1                   -> FAULT cause 1
//             settle_cnt reaches SETTLE_CYCLES      -> NEXT
//             wait_cnt reaches TIMEOUT_CYCLES       -> FAULT cause 2
//            If settle and timeout complete in the same cycle, settle wins.
//   NEXT:    idx==3 -> DONE; else idx++ -> CHECK.
//   DONE:    Done=1 for this one cycle -> IDLE.
//   FAULT:   Fault=1; LockCmd holds its current value (doors already driven keep their state).
//            Clear -> IDLE and zero FaultCause/FaultDoor. Req is ignored.
//  Latency: per door SETTLE_CYCLES+3 cycles (CHECK, DRIVE, SETTLE_CYCLES x WAIT_FB, NEXT) with
//   immediate feedback. Done is high exactly 4*(SETTLE_CYCLES+3)+1 cycles after the acceptance edge.
//  Unlock (cmd=0) never faults on door-open; only timeout applies.
//  Counter widths: $clog2(TIMEOUT_CYCLES+1); counters saturate and never wrap. idx is 2 bits.
//  Door/LockFb are synchronous to clk; synchronisers are outside this block.
// STRUCTURE
//  door_pkg: state encoding (7 states), FaultCause codes (FC_NONE/FC_DOOR_OPEN/FC_TIMEOUT), door index
//   constants DOOR_A..DOOR_D.
//  One sub-module: door_settle_timer. Inputs: match, clear. Outputs: confirmed, timed_out.
//   Contains settle_cnt and wait_cnt, and is parameterised by SETTLE_CYCLES and TIMEOUT_CYCLES.
//  Top level holds the FSM, idx, the latched cmd and the LockCmd register.
// TESTING (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64)
//  1 Lock, all doors closed, LockFb follows LockCmd in the same cycle
//    -> LockCmd steps 0001,0011,0111,1111; Done pulse 29 cycles after accept; Fault=0.
//  2 Lock with Door=4'b0100
//    -> Fault=1, FaultCause=1, FaultDoor=2, LockCmd=4'b0011 held; Clear -> Ready=1, Fault=0.
//  3 Lock, LockFb[1] stuck 0 -> Fault on the 64th WAIT_FB cycle of door B, FaultCause=2, FaultDoor=1.
//  4 LockFb[0] glitches low for 1 cycle after 3 matches -> settle restarts; door A takes 4+4 cycles; Done.
//  5 Door[3] opens during WAIT_FB of door D in a lock -> FAULT cause 1 on the next edge.
//    Unlock from 4'b1111 with Door=4'b1111 -> completes, LockCmd=0000, Done.
//  6 Req held high while Busy -> no second sequence. reset asserted mid-door-C -> next cycle
//    LockCmd=0000, Ready=1, Busy=0.

Source files
------------

// File: rtl/door_pkg.sv
// door_pkg: sequencer state encoding, fault cause codes and door index constants
package door_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DRIVE, S_WAIT_FB, S_NEXT, S_DONE, S_FAULT} state_t;
  typedef enum logic [1:0] {FC_NONE, FC_DOOR_OPEN, FC_TIMEOUT} fault_cause_t;
  localparam logic [1:0] DOOR_A = 2'd0;
  localparam logic [1:0] DOOR_B = 2'd1;
  localparam logic [1:0] DOOR_C = 2'd2;
  localparam logic [1:0] DOOR_D = 2'd3;
endpackage

// File: rtl/door_settle_timer.sv
// door_settle_timer: saturating settle and wait counters; confirmed/timed_out flag the cycle whose count reaches its limit
module door_settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic match,
  input  logic clear,
  output logic confirmed,
  output logic timed_out
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] S_LAST = W'(SETTLE_CYCLES - 1);
  localparam logic [W-1:0] T_LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] T_MAX = W'(TIMEOUT_CYCLES);
  logic [W-1:0] settle_cnt, wait_cnt;
  always_ff @(posedge clk)
    if (rst || clear) begin
      settle_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      settle_cnt <= !match ? '0 : settle_cnt == T_MAX ? settle_cnt : settle_cnt + 1'b1;
      wait_cnt <= wait_cnt == T_MAX ? wait_cnt : wait_cnt + 1'b1;
    end
  assign confirmed = !clear && match && settle_cnt >= S_LAST;
  assign timed_out = !clear && wait_cnt >= T_LAST;
endmodule

// File: rtl/door_lock_sequencer.sv
// door_lock_sequencer: drives door lock actuators A..D in turn, confirms bolt feedback, reports done or fault
module door_lock_sequencer import door_pkg::*; #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic       Cmd,
  output logic       Ready,
  input  logic       Clear,
  input  logic [3:0] Door,
  input  logic [3:0] LockFb,
  output logic [3:0] LockCmd,
  output logic       Busy,
  output logic       Done,
  output logic       Fault,
  output logic [1:0] FaultCause,
  output logic [1:0] FaultDoor
);
  state_t state;
  logic [1:0] idx;
  logic cmd, confirmed, timed_out, door_open;
  door_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(reset),
    .match(LockFb[idx] == cmd),
    .clear(state != S_WAIT_FB),
    .confirmed(confirmed),
    .timed_out(timed_out)
  );
  assign door_open = cmd && Door[idx];
  assign Ready = state == S_IDLE;
  assign Busy = state != S_IDLE && state != S_FAULT;
  assign Done = state == S_DONE;
  assign Fault = state == S_FAULT;
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      idx <= DOOR_A;
      cmd <= 1'b0;
      LockCmd <= '0;
      FaultCause <= FC_NONE;
      FaultDoor <= DOOR_A;
    end else
      case (state)
        S_IDLE:
          if (Req) begin
            cmd <= Cmd;
            idx <= DOOR_A;
            state <= S_CHECK;
          end
        S_CHECK:
          if (door_open) begin
            state <= S_FAULT;
            FaultCause <= FC_DOOR_OPEN;
            FaultDoor <= idx;
          end else
            state <= S_DRIVE;
        S_DRIVE: begin
          LockCmd[idx] <= cmd;
          state <= S_WAIT_FB;
        end
        S_WAIT_FB:
          if (door_open) begin
            state <= S_FAULT;
            FaultCause <= FC_DOOR_OPEN;
            FaultDoor <= idx;
          end else if (confirmed)
            state <= S_NEXT;
          else if (timed_out) begin
            state <= S_FAULT;
            FaultCause <= FC_TIMEOUT;
            FaultDoor <= idx;
          end
        S_NEXT:
          if (idx == DOOR_D)
            state <= S_DONE;
          else begin
            idx <= idx + 2'd1;
            state <= S_CHECK;
          end
        S_DONE: state <= S_IDLE;
        S_FAULT:
          if (Clear) begin
            state <= S_IDLE;
            FaultCause <= FC_NONE;
            FaultDoor <= DOOR_A;
          end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_door_lock_sequencer.sv
// tb_door_lock_sequencer: scoreboard bench comparing timed output snapshots of door_lock_sequencer
module tb_door_lock_sequencer;
  logic clk = 1'b0, reset, Req, Cmd, Clear;
  logic [3:0] Door, LockFb, LockCmd, stuck, glitch;
  logic Ready, Busy, Done, Fault;
  logic [1:0] FaultCause, FaultDoor;
  int cyc = 0, base = 0, n_vec = 0, n_err = 0;
  int due_q[$];
  string tag_q[$];
  logic [11:0] val_q[$];
  door_lock_sequencer #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Cmd(Cmd), .Ready(Ready), .Clear(Clear),
    .Door(Door), .LockFb(LockFb), .LockCmd(LockCmd), .Busy(Busy), .Done(Done),
    .Fault(Fault), .FaultCause(FaultCause), .FaultDoor(FaultDoor)
  );
  assign LockFb = LockCmd & ~stuck & ~glitch;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [11:0] vec(logic r, logic b, logic d, logic f, logic [1:0] fc, logic [1:0] fd, logic [3:0] lc);
    return {r, b, d, f, fc, fd, lc};
  endfunction
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/bsy/dn/flt/fc/fd/lc=%b want %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  always @(negedge clk)
    while (due_q.size() != 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      chk(tag_q.pop_front(), {Ready, Busy, Done, Fault, FaultCause, FaultDoor, LockCmd}, val_q.pop_front());
    end
  task automatic ex(input int d, input string tag, input logic [11:0] v);
    due_q.push_back(base + d);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input logic c);
    base = cyc;
    Req = 1'b1;
    Cmd = c;
  endtask
  task automatic rst_dut(input string tag);
    base = cyc;
    reset = 1'b1;
    ex(1, tag, vec(1, 0, 0, 0, 0, 0, 4'b0000));
    step(1);
    reset = 1'b0;
    step(1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; Req = 1'b0; Cmd = 1'b0; Clear = 1'b0; Door = '0; stuck = '0; glitch = '0;
    step(2);
    rst_dut("reset");
    go(1);
    ex(1, "t1_check", vec(0, 1, 0, 0, 0, 0, 4'b0000));
    ex(3, "t1_doorA", vec(0, 1, 0, 0, 0, 0, 4'b0001));
    ex(10, "t1_doorB", vec(0, 1, 0, 0, 0, 0, 4'b0011));
    ex(17, "t1_doorC", vec(0, 1, 0, 0, 0, 0, 4'b0111));
    ex(24, "t1_doorD", vec(0, 1, 0, 0, 0, 0, 4'b1111));
    ex(28, "t1_pre_done", vec(0, 1, 0, 0, 0, 0, 4'b1111));
    ex(29, "t1_done", vec(0, 1, 1, 0, 0, 0, 4'b1111));
    ex(30, "t1_idle", vec(1, 0, 0, 0, 0, 0, 4'b1111));
    step(1); Req = 1'b0; step(31);
    rst_dut("t2_reset");
    Door = 4'b0100;
    go(1);
    ex(16, "t2_open_fault", vec(0, 0, 0, 1, 1, 2, 4'b0011));
    step(1); Req = 1'b0; step(16);
    Req = 1'b1;
    ex(20, "t2_req_ignored", vec(0, 0, 0, 1, 1, 2, 4'b0011));
    step(1); Req = 1'b0; step(3);
    Clear = 1'b1;
    ex(22, "t2_clear", vec(1, 0, 0, 0, 0, 0, 4'b0011));
    step(1); Clear = 1'b0; Door = '0; step(2);
    stuck = 4'b0010;
    go(1);
    ex(73, "t3_wait64", vec(0, 1, 0, 0, 0, 0, 4'b0011));
    ex(74, "t3_timeout", vec(0, 0, 0, 1, 2, 1, 4'b0011));
    step(1); Req = 1'b0; step(75);
    Clear = 1'b1;
    ex(77, "t3_clear", vec(1, 0, 0, 0, 0, 0, 4'b0011));
    step(1); Clear = 1'b0; stuck = '0; step(2);
    rst_dut("t4_reset");
    go(1);
    ex(10, "t4_doorA_slow", vec(0, 1, 0, 0, 0, 0, 4'b0001));
    ex(14, "t4_doorB", vec(0, 1, 0, 0, 0, 0, 4'b0011));
    ex(32, "t4_pre_done", vec(0, 1, 0, 0, 0, 0, 4'b1111));
    ex(33, "t4_done", vec(0, 1, 1, 0, 0, 0, 4'b1111));
    ex(34, "t4_idle", vec(1, 0, 0, 0, 0, 0, 4'b1111));
    step(1); Req = 1'b0; step(5);
    glitch = 4'b0001;
    step(1); glitch = '0; step(28);
    go(1);
    ex(25, "t5_waitD", vec(0, 1, 0, 0, 0, 0, 4'b1111));
    ex(26, "t5_doorD_open", vec(0, 0, 0, 1, 1, 3, 4'b1111));
    step(1); Req = 1'b0; step(24);
    Door = 4'b1000;
    step(3);
    Clear = 1'b1;
    ex(29, "t5_clear", vec(1, 0, 0, 0, 0, 0, 4'b1111));
    step(1); Clear = 1'b0; Door = 4'b1111; step(1);
    go(0);
    ex(3, "t5_unlockA", vec(0, 1, 0, 0, 0, 0, 4'b1110));
    ex(10, "t5_unlockB", vec(0, 1, 0, 0, 0, 0, 4'b1100));
    ex(17, "t5_unlockC", vec(0, 1, 0, 0, 0, 0, 4'b1000));
    ex(24, "t5_unlockD", vec(0, 1, 0, 0, 0, 0, 4'b0000));
    ex(29, "t5_unlock_done", vec(0, 1, 1, 0, 0, 0, 4'b0000));
    ex(30, "t5_unlock_idle", vec(1, 0, 0, 0, 0, 0, 4'b0000));
    step(1); Req = 1'b0; step(31);
    Door = '0;
    go(1);
    ex(10, "t6_busy_req_doorB", vec(0, 1, 0, 0, 0, 0, 4'b0011));
    ex(29, "t6_done", vec(0, 1, 1, 0, 0, 0, 4'b1111));
    ex(30, "t6_idle", vec(1, 0, 0, 0, 0, 0, 4'b1111));
    step(20); Req = 1'b0; step(12);
    rst_dut("t6_reset");
    go(1);
    ex(17, "t6_doorC", vec(0, 1, 0, 0, 0, 0, 4'b0111));
    ex(18, "t6_abort", vec(1, 0, 0, 0, 0, 0, 4'b0000));
    step(1); Req = 1'b0; step(16);
    reset = 1'b1;
    step(1); reset = 1'b0;
    ex(20, "t6_post_abort", vec(1, 0, 0, 0, 0, 0, 4'b0000));
    step(4);
    while (due_q.size() != 0) begin
      void'(due_q.pop_front());
      chk({tag_q.pop_front(), "_unreached"}, 12'bx, val_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
